uop_sequencer: RTL and testbench

//  Sequences the up-to-three micro-op slots produced by the instruction decoder onto the register file / ALU datapath.

---
 rtl/uop_sequencer_pkg.sv | 50 +++++
 rtl/uop_sequencer_slot_pick.sv | 35 +++
 rtl/uop_sequencer.sv | 171 +++++++++++++++++
 tb/tb_uop_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_sequencer_pkg.sv
// Shared definitions for the micro-op sequencer: code widths, load/select codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package uop_sequencer_pkg;

   localparam int SEQ_CODE_W = 4;

   // Highest valid load code and the code that targets EIP
   localparam logic [SEQ_CODE_W-1:0] SEQ_MAX_CODE = 4'h6;
   localparam logic [SEQ_CODE_W-1:0] SEQ_EIP_CODE = 4'h4;

   // Load-destination / ALU-source codes shared with the decoder
   localparam logic [SEQ_CODE_W-1:0] CODE_NONE         = 4'h0;
   localparam logic [SEQ_CODE_W-1:0] CODE_ESP          = 4'h1;
   localparam logic [SEQ_CODE_W-1:0] CODE_EBP          = 4'h2;
   localparam logic [SEQ_CODE_W-1:0] CODE_EAX          = 4'h3;
   localparam logic [SEQ_CODE_W-1:0] CODE_EIP          = 4'h4;
   localparam logic [SEQ_CODE_W-1:0] CODE_STACK_ACCESS = 4'h5;
   localparam logic [SEQ_CODE_W-1:0] CODE_EDI          = 4'h6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_S1     = 3'd1,
      ST_S2     = 3'd2,
      ST_S3     = 3'd3,
      ST_ADV    = 3'd4,
      ST_WFETCH = 3'd5
   } seq_state_t;

   // Slot index (1..3) to the state that issues it; anything else means "go advance EIP"
   function automatic seq_state_t slot_state(input logic [1:0] idx);
      case (idx)
         2'd1:    return ST_S1;
         2'd2:    return ST_S2;
         2'd3:    return ST_S3;
         default: return ST_ADV;
      endcase
   endfunction

   // Slot index currently being issued; 0 when not in a slot state
   function automatic logic [1:0] state_slot(input seq_state_t s);
      case (s)
         ST_S1:   return 2'd1;
         ST_S2:   return 2'd2;
         ST_S3:   return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/uop_sequencer_slot_pick.sv
// Picks the next active slot after the current one (index 0 = start of instruction).
// Latency: combinational.
// Backpressure: none; caller decides when to advance.
module uop_slot_pick (
   input  logic [2:0] i_act,
   input  logic [1:0] i_idx,
   output logic [1:0] o_next,
   output logic       o_done
);

   // Search strictly after the current index so empty slots are skipped without a bubble
   always_comb begin
      o_next = 2'd0;
      o_done = 1'b1;
      case (i_idx)
         2'd0: begin
            if (i_act[0])      begin o_next = 2'd1; o_done = 1'b0; end
            else if (i_act[1]) begin o_next = 2'd2; o_done = 1'b0; end
            else if (i_act[2]) begin o_next = 2'd3; o_done = 1'b0; end
         end
         2'd1: begin
            if (i_act[1])      begin o_next = 2'd2; o_done = 1'b0; end
            else if (i_act[2]) begin o_next = 2'd3; o_done = 1'b0; end
         end
         2'd2: begin
            if (i_act[2])      begin o_next = 2'd3; o_done = 1'b0; end
         end
         default: begin
            o_next = 2'd0;
            o_done = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/uop_sequencer.sv
// Issues up to three decoded micro-op slots, one per cycle, then advances EIP and requests the next fetch.
// Latency: ope_ack in the capture cycle, first step registered one cycle later, one step per unstalled cycle.
// Backpressure: stall freezes the current step; ope_valid is only acked in IDLE.
module uop_sequencer
   import uop_sequencer_pkg::*;
#(
   parameter int                CODE_W   = SEQ_CODE_W,
   parameter logic [CODE_W-1:0] MAX_CODE = SEQ_MAX_CODE,
   parameter logic [CODE_W-1:0] EIP_CODE = SEQ_EIP_CODE
) (
   input  logic              clk2,
   input  logic              reset,
   input  logic              ope_valid,
   output logic              ope_ack,
   input  logic [CODE_W-1:0] reg_load_1,
   input  logic [CODE_W-1:0] reg_load_2,
   input  logic [CODE_W-1:0] reg_load_3,
   input  logic [CODE_W-1:0] select_1,
   input  logic [CODE_W-1:0] select_2,
   input  logic [CODE_W-1:0] select_3,
   input  logic [3:0]        num_of_ope,
   input  logic              stall,
   output logic [CODE_W-1:0] ld_code,
   output logic [CODE_W-1:0] alu_sel,
   output logic              step_valid,
   output logic              eip_adv,
   output logic [3:0]        eip_amt,
   output logic              fetch_req,
   output logic              illegal,
   output logic              busy
);

   // A slot is live only for codes 1..MAX_CODE; unknown codes fall through the if and read as empty
   function automatic logic slot_active(input logic [CODE_W-1:0] c);
      if ((c != '0) && (c <= MAX_CODE)) return 1'b1;
      return 1'b0;
   endfunction

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [CODE_W-1:0] r_ld1, r_ld2, r_ld3;
   logic [CODE_W-1:0] r_sel1, r_sel2, r_sel3;
   logic [2:0]        r_act;
   logic              r_any_active;
   logic              r_eip_written;
   logic [CODE_W-1:0] r_ld_code;
   logic [CODE_W-1:0] r_alu_sel;
   logic              r_step_valid;

   logic [2:0]        w_live_act;
   logic [2:0]        w_act_src;
   logic [1:0]        w_cur_idx;
   logic [1:0]        w_pick_next;
   logic              w_pick_done;
   logic              w_is_idle;
   logic              w_in_adv;
   logic              w_capture;
   logic              w_advance;
   logic [CODE_W-1:0] w_step_ld;
   logic [CODE_W-1:0] w_step_sel;

   assign w_live_act = {slot_active(reg_load_3), slot_active(reg_load_2), slot_active(reg_load_1)};
   assign w_is_idle  = (r_state == ST_IDLE);
   assign w_in_adv   = (r_state == ST_ADV);
   // In IDLE the first slot is chosen from the decoder's live outputs, afterwards from the captured copy
   assign w_act_src  = w_is_idle ? w_live_act : r_act;
   assign w_cur_idx  = state_slot(r_state);

   uop_slot_pick u_pick (
      .i_act  (w_act_src),
      .i_idx  (w_cur_idx),
      .o_next (w_pick_next),
      .o_done (w_pick_done)
   );

   // Fetch the load/select pair of the slot about to be issued
   always_comb begin
      w_step_ld  = '0;
      w_step_sel = '0;
      case (w_pick_next)
         2'd1: begin
            w_step_ld  = w_is_idle ? reg_load_1 : r_ld1;
            w_step_sel = w_is_idle ? select_1   : r_sel1;
         end
         2'd2: begin
            w_step_ld  = w_is_idle ? reg_load_2 : r_ld2;
            w_step_sel = w_is_idle ? select_2   : r_sel2;
         end
         2'd3: begin
            w_step_ld  = w_is_idle ? reg_load_3 : r_ld3;
            w_step_sel = w_is_idle ? select_3   : r_sel3;
         end
         default: begin
            w_step_ld  = '0;
            w_step_sel = '0;
         end
      endcase
   end

   // Next-state logic: capture in IDLE, step through active slots unless stalled, ADV and WFETCH last one cycle each
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ope_valid) begin
               w_capture = 1'b1;
               w_advance = 1'b1;
            end
         end
         ST_S1, ST_S2, ST_S3: begin
            if (!stall) w_advance = 1'b1;
         end
         ST_ADV:    w_state_nxt = ST_WFETCH;
         ST_WFETCH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (w_advance) w_state_nxt = w_pick_done ? ST_ADV : slot_state(w_pick_next);
   end

   // State, captured slots and registered step outputs; eip_written is cleared on capture and set by an issued EIP load
   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_ld1         <= '0;
         r_ld2         <= '0;
         r_ld3         <= '0;
         r_sel1        <= '0;
         r_sel2        <= '0;
         r_sel3        <= '0;
         r_act         <= 3'b000;
         r_any_active  <= 1'b0;
         r_eip_written <= 1'b0;
         r_ld_code     <= '0;
         r_alu_sel     <= '0;
         r_step_valid  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_ld1         <= reg_load_1;
            r_ld2         <= reg_load_2;
            r_ld3         <= reg_load_3;
            r_sel1        <= select_1;
            r_sel2        <= select_2;
            r_sel3        <= select_3;
            r_act         <= w_live_act;
            r_any_active  <= |w_live_act;
            r_eip_written <= 1'b0;
         end
         if (w_advance) begin
            r_ld_code    <= w_pick_done ? '0 : w_step_ld;
            r_alu_sel    <= w_pick_done ? '0 : w_step_sel;
            r_step_valid <= ~w_pick_done;
            if (!w_pick_done && (w_step_ld == EIP_CODE)) r_eip_written <= 1'b1;
         end
      end
   end

   // Ack is gated by reset so nothing is reported while the block is held in reset
   assign ope_ack    = w_capture & ~reset;
   assign busy       = ~w_is_idle;
   assign ld_code    = r_ld_code;
   assign alu_sel    = r_alu_sel;
   assign step_valid = r_step_valid;
   assign eip_adv    = w_in_adv & ~r_eip_written;
   assign eip_amt    = eip_adv ? num_of_ope : 4'd0;
   assign fetch_req  = w_in_adv;
   assign illegal    = w_in_adv & ~r_any_active & (num_of_ope == 4'd0);

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: directed instruction cases plus randomized back-to-back traffic.
// Latency: expected per-cycle traces come from a queue-based model of the issue order.
// Backpressure: random stall patterns and random ope_valid outside IDLE.
module tb_uop_sequencer;

   logic       clk2 = 1'b0;
   logic       reset;
   logic       ope_valid;
   logic       ope_ack;
   logic [3:0] reg_load_1, reg_load_2, reg_load_3;
   logic [3:0] select_1, select_2, select_3;
   logic [3:0] num_of_ope;
   logic       stall;
   logic [3:0] ld_code, alu_sel, eip_amt;
   logic       step_valid, eip_adv, fetch_req, illegal, busy;

   int tests = 0;
   int fails = 0;

   // Observation vector: {ack, step_valid, ld[4], sel[4], eip_adv, amt[4], fetch_req, illegal, busy}
   logic [17:0] exp_arr [0:127];
   logic [17:0] obs_arr [0:127];

   uop_sequencer dut (
      .clk2       (clk2),
      .reset      (reset),
      .ope_valid  (ope_valid),
      .ope_ack    (ope_ack),
      .reg_load_1 (reg_load_1),
      .reg_load_2 (reg_load_2),
      .reg_load_3 (reg_load_3),
      .select_1   (select_1),
      .select_2   (select_2),
      .select_3   (select_3),
      .num_of_ope (num_of_ope),
      .stall      (stall),
      .ld_code    (ld_code),
      .alu_sel    (alu_sel),
      .step_valid (step_valid),
      .eip_adv    (eip_adv),
      .eip_amt    (eip_amt),
      .fetch_req  (fetch_req),
      .illegal    (illegal),
      .busy       (busy)
   );

   always #5 clk2 = ~clk2;

   function automatic logic [17:0] mk(input logic a, input logic sv, input logic [3:0] ld,
                                      input logic [3:0] sel, input logic adv, input logic [3:0] amt,
                                      input logic fr, input logic il, input logic bs);
      return {a, sv, ld, sel, adv, amt, fr, il, bs};
   endfunction

   function automatic logic [17:0] observe();
      return {ope_ack, step_valid, ld_code, alu_sel, eip_adv, eip_amt, fetch_req, illegal, busy};
   endfunction

   function automatic bit is_active(input logic [3:0] c);
      return ((c >= 4'd1) && (c <= 4'd6)) === 1'b1;
   endfunction

   // Reference: the active slots form a queue; each unstalled cycle pops one, then one ADV and one WFETCH cycle
   task automatic build_exp(input logic [11:0] lds, input logic [11:0] sels, input logic [3:0] num,
                            input logic [63:0] stl, output int n);
      logic [7:0] steps[$];
      logic [3:0] l;
      bit ew;
      int c;
      int pos;
      ew = 1'b0;
      for (int k = 0; k < 3; k++) begin
         l = lds[k*4 +: 4];
         if (is_active(l)) begin
            steps.push_back({l, sels[k*4 +: 4]});
            if (l == 4'd4) ew = 1'b1;
         end
      end
      c = 0;
      exp_arr[c] = mk(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      c = c + 1;
      pos = 0;
      while (pos < steps.size()) begin
         exp_arr[c] = mk(1'b0, 1'b1, steps[pos][7:4], steps[pos][3:0], 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
         if (!((c < 64) && stl[c])) pos = pos + 1;
         c = c + 1;
      end
      exp_arr[c] = mk(1'b0, 1'b0, 4'd0, 4'd0, !ew, ew ? 4'd0 : num, 1'b1,
                      (steps.size() == 0) && (num == 4'd0), 1'b1);
      c = c + 1;
      exp_arr[c] = mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      n = c + 1;
   endtask

   // Drives one instruction starting in an IDLE cycle and records n cycles of outputs
   task automatic exec(input logic [11:0] lds, input logic [11:0] sels, input logic [3:0] num,
                       input logic [63:0] stl, input bit hold, input int n);
      for (int c = 0; c < n; c++) begin
         if (c == 0) begin
            ope_valid  = 1'b1;
            reg_load_1 = lds[3:0];
            reg_load_2 = lds[7:4];
            reg_load_3 = lds[11:8];
            select_1   = sels[3:0];
            select_2   = sels[7:4];
            select_3   = sels[11:8];
            num_of_ope = num;
         end else begin
            ope_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
         end
         stall = (c < 64) ? stl[c] : 1'b0;
         @(negedge clk2);
         obs_arr[c] = observe();
         @(posedge clk2);
         #1;
      end
      ope_valid = 1'b0;
      stall     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ope_valid = 1'b0;
      stall = 1'b0;
      reg_load_1 = 4'd0; reg_load_2 = 4'd0; reg_load_3 = 4'd0;
      select_1 = 4'd0; select_2 = 4'd0; select_3 = 4'd0;
      num_of_ope = 4'd0;
      repeat (3) @(posedge clk2);
      #1;
      tests++;
      if (observe() !== 18'd0) begin
         fails++;
         $display("FAIL reset_held: got %h expected %h", observe(), 18'd0);
      end
      @(negedge clk2);
      reset = 1'b0;
      @(posedge clk2);
      #1;
      tests++;
      if (observe() !== 18'd0) begin
         fails++;
         $display("FAIL reset_released: got %h expected %h", observe(), 18'd0);
      end
   endtask

   task automatic test_push_ebp();
      logic [11:0] l, s;
      int n;
      l = {4'h0, 4'h1, 4'h1};
      s = {4'h0, 4'h1, 4'h2};
      build_exp(l, s, 4'd1, 64'd0, n);
      exec(l, s, 4'd1, 64'd0, 1'b0, n);
      for (int c = 0; c < n; c++) begin
         tests++;
         if (obs_arr[c] !== exp_arr[c]) begin
            fails++;
            $display("FAIL push_ebp cycle %0d: got %h expected %h", c, obs_arr[c], exp_arr[c]);
         end
      end
      tests++;
      if ({obs_arr[1][16:8], obs_arr[2][16:8], obs_arr[3][7:2]} !== {9'h112, 9'h111, 1'b1, 4'd1, 1'b1}) begin
         fails++;
         $display("FAIL push_ebp_directed: got %h %h %h", obs_arr[1][16:8], obs_arr[2][16:8], obs_arr[3][7:2]);
      end
   endtask

   task automatic test_call();
      logic [11:0] l, s;
      int n;
      l = {4'h4, 4'h1, 4'h1};
      s = {4'h2, 4'h3, 4'h2};
      build_exp(l, s, 4'd5, 64'd0, n);
      exec(l, s, 4'd5, 64'd0, 1'b0, n);
      for (int c = 0; c < n; c++) begin
         tests++;
         if (obs_arr[c] !== exp_arr[c]) begin
            fails++;
            $display("FAIL call cycle %0d: got %h expected %h", c, obs_arr[c], exp_arr[c]);
         end
      end
      tests++;
      if ({obs_arr[3][16:8], obs_arr[4][7:2]} !== {9'h142, 1'b0, 4'd0, 1'b1}) begin
         fails++;
         $display("FAIL call_directed: got %h %h expected 142 01", obs_arr[3][16:8], obs_arr[4][7:2]);
      end
   endtask

   task automatic test_mov_imm();
      logic [11:0] l, s;
      int n;
      l = {4'hx, 4'hx, 4'h3};
      s = {4'hx, 4'hx, 4'h3};
      build_exp(l, s, 4'd5, 64'd0, n);
      exec(l, s, 4'd5, 64'd0, 1'b0, n);
      for (int c = 0; c < n; c++) begin
         tests++;
         if (obs_arr[c] !== exp_arr[c]) begin
            fails++;
            $display("FAIL mov_imm cycle %0d: got %h expected %h", c, obs_arr[c], exp_arr[c]);
         end
      end
      tests++;
      if (obs_arr[1][16:8] !== 9'h133) begin
         fails++;
         $display("FAIL mov_imm_first_step: got %h expected 133", obs_arr[1][16:8]);
      end
   endtask

   task automatic test_stall();
      logic [11:0] l, s;
      logic [63:0] stl;
      int n;
      int adv_cnt;
      l = {4'h6, 4'h2, 4'h1};
      s = {4'h5, 4'h4, 4'h3};
      stl = 64'b11100;
      build_exp(l, s, 4'd3, stl, n);
      exec(l, s, 4'd3, stl, 1'b0, n);
      adv_cnt = 0;
      for (int c = 0; c < n; c++) begin
         tests++;
         if (obs_arr[c] !== exp_arr[c]) begin
            fails++;
            $display("FAIL stall cycle %0d: got %h expected %h", c, obs_arr[c], exp_arr[c]);
         end
         if (obs_arr[c][7]) adv_cnt++;
      end
      tests++;
      if ({obs_arr[2][16:8], obs_arr[5][16:8], obs_arr[6][16:8]} !== {9'h124, 9'h124, 9'h165}) begin
         fails++;
         $display("FAIL stall_hold: got %h %h %h expected 124 124 165",
                  obs_arr[2][16:8], obs_arr[5][16:8], obs_arr[6][16:8]);
      end
      tests++;
      if (adv_cnt !== 1) begin
         fails++;
         $display("FAIL stall_eip_adv_count: got %0d expected 1", adv_cnt);
      end
   endtask

   task automatic test_reset_mid();
      ope_valid  = 1'b1;
      reg_load_1 = 4'h1; reg_load_2 = 4'h2; reg_load_3 = 4'h5;
      select_1   = 4'h1; select_2   = 4'h6; select_3   = 4'h2;
      num_of_ope = 4'd3;
      @(posedge clk2);
      #1;
      ope_valid = 1'b0;
      @(posedge clk2);
      #1;
      tests++;
      if (observe() !== mk(1'b0, 1'b1, 4'h2, 4'h6, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1)) begin
         fails++;
         $display("FAIL reset_mid_pre: got %h expected step 2/6", observe());
      end
      reset = 1'b1;
      #1;
      tests++;
      if (observe() !== 18'd0) begin
         fails++;
         $display("FAIL reset_mid_async: got %h expected %h", observe(), 18'd0);
      end
      @(negedge clk2);
      @(negedge clk2);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk2);
         tests++;
         if (observe() !== 18'd0) begin
            fails++;
            $display("FAIL reset_mid_after cycle %0d: got %h expected %h", c, observe(), 18'd0);
         end
      end
      @(posedge clk2);
      #1;
   endtask

   task automatic test_illegal_hold();
      logic [11:0] l, s;
      int n;
      bit done;
      bit seen_ill;
      l = 12'h000;
      s = 12'h000;
      build_exp(l, s, 4'd0, 64'd0, n);
      exec(l, s, 4'd0, 64'd0, 1'b1, n);
      for (int c = 0; c < n; c++) begin
         tests++;
         if (obs_arr[c] !== exp_arr[c]) begin
            fails++;
            $display("FAIL illegal cycle %0d: got %h expected %h", c, obs_arr[c], exp_arr[c]);
         end
      end
      ope_valid = 1'b1;
      @(negedge clk2);
      tests++;
      if ({ope_ack, busy} !== 2'b10) begin
         fails++;
         $display("FAIL illegal_reack: got ack=%b busy=%b expected ack=1 busy=0", ope_ack, busy);
      end
      @(posedge clk2);
      #1;
      ope_valid = 1'b0;
      done = 1'b0;
      seen_ill = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk2);
         if (illegal === 1'b1) seen_ill = 1'b1;
         if (busy === 1'b0) done = 1'b1;
         @(posedge clk2);
         #1;
      end
      tests++;
      if ({done, seen_ill} !== 2'b11) begin
         fails++;
         $display("FAIL illegal_drain: got done=%b illegal_seen=%b expected 1 1", done, seen_ill);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] l, s;
      logic [3:0]  num;
      logic [63:0] stl;
      int n;
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < 3; k++) begin
            l[k*4 +: 4] = 4'($urandom_range(0, 9));
            s[k*4 +: 4] = 4'($urandom_range(0, 15));
         end
         num = 4'($urandom_range(0, 15));
         for (int k = 0; k < 64; k++) stl[k] = ($urandom_range(0, 3) == 0);
         build_exp(l, s, num, stl, n);
         exec(l, s, num, stl, 1'b0, n);
         for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_arr[c] !== exp_arr[c]) begin
               fails++;
               $display("FAIL random it %0d cycle %0d: got %h expected %h", it, c, obs_arr[c], exp_arr[c]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_push_ebp();
      test_call();
      test_mov_imm();
      test_stall();
      test_reset_mid();
      test_illegal_hold();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
